// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line engine: receives 48-bit host commands, validates framing and CRC7,
// and drives a short (48-bit) or long (136-bit) response after an NCR gap.
module sd_card_cmd_responder #(
    parameter int NCR     = 2,
    parameter int NCR_MAX = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cmd_in,
    output logic         cmd_out,
    output logic         cmd_oe,
    output logic         cmd_valid,
    output logic [5:0]   cmd_index,
    output logic [31:0]  cmd_arg,
    output logic         crc_error,
    output logic         frame_error,
    input  logic         resp_start,
    input  logic [1:0]   resp_type,
    input  logic [119:0] resp_payload,
    output logic         resp_timeout,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RECV      = 3'd1,
        S_CHECK     = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_GAP       = 3'd4,
        S_SEND      = 3'd5
    } state_t;

    localparam logic [7:0] RX_LAST    = 8'd47;
    localparam logic [7:0] WAIT_LAST  = 8'(NCR_MAX - 1);
    localparam logic [7:0] GAP_LAST   = 8'(NCR - 1);
    localparam logic [7:0] SHORT_LAST = 8'd47;
    localparam logic [7:0] LONG_LAST  = 8'd135;

    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    function automatic logic [6:0] crc7_40(input logic [39:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    function automatic logic [6:0] crc7_120(input logic [119:0] d);
        logic [6:0] c;
        c = 7'd0;
        for (int i = 119; i >= 0; i--) c = crc7_step(c, d[i]);
        return c;
    endfunction

    // Response frames are left-aligned so SEND always shifts out bit 135.
    function automatic logic [135:0] short_frame(input logic [37:0] p);
        logic [39:0] body;
        body = {2'b00, p};
        return {body, crc7_40(body), 1'b1, 88'd0};
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] p);
        return {2'b00, 6'b111111, p, crc7_120(p), 1'b1};
    endfunction

    state_t         state_q, state_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [47:0]    rx_q, rx_d;
    logic [135:0]   tx_q, tx_d;
    logic           long_q, long_d;
    logic           cmd_out_q, cmd_out_d;
    logic           cmd_oe_q, cmd_oe_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           crc_error_q, crc_error_d;
    logic           frame_error_q, frame_error_d;
    logic           resp_timeout_q, resp_timeout_d;
    logic           busy_q, busy_d;
    logic [5:0]     cmd_index_q, cmd_index_d;
    logic [31:0]    cmd_arg_q, cmd_arg_d;

    // Next-state and registered-output logic; outputs are derived from the next state.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rx_d           = rx_q;
        tx_d           = tx_q;
        long_d         = long_q;
        cmd_out_d      = 1'b1;
        cmd_oe_d       = 1'b0;
        cmd_valid_d    = 1'b0;
        crc_error_d    = 1'b0;
        frame_error_d  = 1'b0;
        resp_timeout_d = 1'b0;
        cmd_index_d    = cmd_index_q;
        cmd_arg_d      = cmd_arg_q;
        case (state_q)
            S_IDLE: begin
                if (!cmd_in) begin
                    state_d = S_RECV;
                    cnt_d   = 8'd1;
                    rx_d    = 48'd0;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            S_RECV: begin
                rx_d  = {rx_q[46:0], cmd_in};
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == RX_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_CHECK: begin
                cnt_d = 8'd0;
                if (!rx_q[46] || !rx_q[0]) begin
                    frame_error_d = 1'b1;
                    state_d       = S_IDLE;
                end else if (crc7_40(rx_q[47:8]) != rx_q[7:1]) begin
                    crc_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_index_d = rx_q[45:40];
                    cmd_arg_d   = rx_q[39:8];
                    state_d     = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                if (resp_start) begin
                    cnt_d = 8'd0;
                    if (resp_type == 2'd0) begin
                        state_d = S_IDLE;
                    end else begin
                        long_d   = (resp_type == 2'd1);
                        tx_d     = (resp_type == 2'd1) ? long_frame(resp_payload)
                                                       : short_frame(resp_payload[37:0]);
                        state_d  = S_GAP;
                        cmd_oe_d = 1'b1;
                    end
                end else if (cnt_q == WAIT_LAST) begin
                    resp_timeout_d = 1'b1;
                    cnt_d          = 8'd0;
                    state_d        = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                cmd_oe_d = 1'b1;
                if (cnt_q == GAP_LAST) begin
                    state_d   = S_SEND;
                    cnt_d     = 8'd0;
                    cmd_out_d = tx_q[135];
                    tx_d      = {tx_q[134:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_SEND: begin
                if (cnt_q == (long_q ? LONG_LAST : SHORT_LAST)) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cmd_oe_d  = 1'b1;
                    cmd_out_d = tx_q[135];
                    tx_d      = {tx_q[134:0], 1'b0};
                    cnt_d     = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 8'd0;
            rx_q           <= 48'd0;
            tx_q           <= 136'd0;
            long_q         <= 1'b0;
            cmd_out_q      <= 1'b1;
            cmd_oe_q       <= 1'b0;
            cmd_valid_q    <= 1'b0;
            crc_error_q    <= 1'b0;
            frame_error_q  <= 1'b0;
            resp_timeout_q <= 1'b0;
            busy_q         <= 1'b0;
            cmd_index_q    <= 6'd0;
            cmd_arg_q      <= 32'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_q           <= rx_d;
            tx_q           <= tx_d;
            long_q         <= long_d;
            cmd_out_q      <= cmd_out_d;
            cmd_oe_q       <= cmd_oe_d;
            cmd_valid_q    <= cmd_valid_d;
            crc_error_q    <= crc_error_d;
            frame_error_q  <= frame_error_d;
            resp_timeout_q <= resp_timeout_d;
            busy_q         <= busy_d;
            cmd_index_q    <= cmd_index_d;
            cmd_arg_q      <= cmd_arg_d;
        end
    end

    assign cmd_out      = cmd_out_q;
    assign cmd_oe       = cmd_oe_q;
    assign cmd_valid    = cmd_valid_q;
    assign crc_error    = crc_error_q;
    assign frame_error  = frame_error_q;
    assign resp_timeout = resp_timeout_q;
    assign busy         = busy_q;
    assign cmd_index    = cmd_index_q;
    assign cmd_arg      = cmd_arg_q;

endmodule
